// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if
// Bundles every non-clock signal of uart_tx_arbiter.
//   master : the surroundings (requesters plus uart_tx), drives req_* and tx_busy
//   slave  : the arbiter, drives req_ready, tx_data, tx_start, grant_id, active
// Signals:
//   req_valid [NUM_REQ]    requester i offers a byte on req_data[8*i +: 8]
//   req_data  [8*NUM_REQ]  packed request bytes
//   req_last  [NUM_REQ]    byte ends its packet (packet-lock builds only)
//   req_ready [NUM_REQ]    one-hot accept, combinational
//   tx_data   [8]          byte to uart_tx, held from tx_start to the next accept
//   tx_start               one-cycle start pulse to uart_tx
//   tx_busy                uart_tx is shifting (high in the tx_start cycle too)
//   grant_id  [GID_W]      index of the most recently accepted requester
//   active                 a byte is in flight or a packet lock is held
//   dbg_state [2]          arbiter FSM state (0 ARB, 1 START, 2 WAIT)
interface uart_tx_arbiter_if #(
   parameter int NUM_REQ = 4
);
   localparam int GID_W = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]   req_valid;
   logic [8*NUM_REQ-1:0] req_data;
   logic [NUM_REQ-1:0]   req_last;
   logic [NUM_REQ-1:0]   req_ready;
   logic [7:0]           tx_data;
   logic                 tx_start;
   logic                 tx_busy;
   logic [GID_W-1:0]     grant_id;
   logic                 active;
   logic [1:0]           dbg_state;

   modport master (
      output req_valid, req_data, req_last, tx_busy,
      input  req_ready, tx_data, tx_start, grant_id, active, dbg_state
   );

   modport slave (
      input  req_valid, req_data, req_last, tx_busy,
      output req_ready, tx_data, tx_start, grant_id, active, dbg_state
   );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Round-robin scheduler sharing a single uart_tx serializer between NUM_REQ
// byte-stream requesters. A byte is taken from one requester, handed to
// uart_tx with a one-cycle tx_start pulse, and no new byte is taken until
// uart_tx reports tx_busy low.
// Ports:
//   clk    system clock (same clock as uart_tx)
//   rst_n  asynchronous active-low reset
//   bus    uart_tx_arbiter_if.slave (requester handshake, uart_tx side,
//          grant_id, active, dbg_state)
// Optional feature, macro UART_ARB_PKT_LOCK_EN: a byte accepted with
// req_last=0 locks the arbiter onto that requester until its req_last=1
// byte, so multi-byte packets are never interleaved on the line.
//
// Handshake: requester i hands over its byte in the cycle where
// req_valid[i] && req_ready[i]. req_ready is combinational, at most one bit
// high, and only in ARB with tx_busy low; it may depend on req_valid in the
// same cycle. req_valid may drop without an accept, nothing is consumed.
module uart_tx_arbiter #(
   parameter int NUM_REQ = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   uart_tx_arbiter_if.slave bus
);
   localparam int GID_W = $clog2(NUM_REQ);

   typedef enum logic [1:0] {
      ARB   = 2'd0,
      START = 2'd1,
      WAIT  = 2'd2
   } state_t;

   state_t             state;
   logic [GID_W-1:0]   rr_ptr;
   logic [GID_W-1:0]   grant_q;
   logic [7:0]         tx_data_q;
   logic               tx_start_q;
   logic               active_q;
   logic               lock_held;
   logic [NUM_REQ-1:0] cand;
   logic [GID_W-1:0]   win_id;
   logic               win_found;
   logic               accept;
   logic [GID_W-1:0]   next_ptr;
   logic [7:0]         req_byte [NUM_REQ];

`ifdef UART_ARB_PKT_LOCK_EN
   logic             lock_q;
   logic [GID_W-1:0] lock_id;

   assign lock_held = lock_q;
   // While locked only the owning requester may win.
   assign cand = lock_q ? (bus.req_valid & (NUM_REQ'(1) << lock_id)) : bus.req_valid;
`else
   logic unused_req_last;

   assign unused_req_last = ^bus.req_last;
   assign lock_held       = 1'b0;
   assign cand            = bus.req_valid;
`endif

   always_comb begin
      for (int j = 0; j < NUM_REQ; j++) begin
         req_byte[j] = bus.req_data[8*j +: 8];
      end
   end

   // First candidate at or after rr_ptr, wrapping modulo NUM_REQ.
   always_comb begin
      logic [GID_W-1:0] idx;
      win_found = 1'b0;
      win_id    = '0;
      idx       = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = GID_W'((int'(rr_ptr) + k) % NUM_REQ);
         if (!win_found && cand[idx]) begin
            win_found = 1'b1;
            win_id    = idx;
         end
      end
   end

   // Gated by rst_n so req_ready stays 0 throughout reset.
   assign accept        = rst_n && (state == ARB) && !bus.tx_busy && win_found;
   assign bus.req_ready = accept ? (NUM_REQ'(1) << win_id) : '0;
   assign next_ptr      = GID_W'((int'(grant_q) + 1) % NUM_REQ);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ARB;
         rr_ptr     <= '0;
         grant_q    <= '0;
         tx_data_q  <= 8'h00;
         tx_start_q <= 1'b0;
         active_q   <= 1'b0;
`ifdef UART_ARB_PKT_LOCK_EN
         lock_q     <= 1'b0;
         lock_id    <= '0;
`endif
      end else begin
         case (state)
            ARB: begin
               if (accept) begin
                  tx_data_q  <= req_byte[win_id];
                  grant_q    <= win_id;
                  tx_start_q <= 1'b1;
                  active_q   <= 1'b1;
                  state      <= START;
`ifdef UART_ARB_PKT_LOCK_EN
                  // A last byte releases the lock; any other byte (re)takes it.
                  lock_q     <= !bus.req_last[win_id];
                  lock_id    <= win_id;
`endif
               end
            end
            START: begin
               tx_start_q <= 1'b0;
               state      <= WAIT;
            end
            WAIT: begin
               if (!bus.tx_busy) begin
                  state    <= ARB;
                  active_q <= lock_held;
                  // Under lock the pointer stays put; it moves past the owner
                  // once the packet's last byte has gone out.
                  if (!lock_held) begin
                     rr_ptr <= next_ptr;
                  end
               end
            end
            default: state <= ARB;
         endcase
      end
   end

   assign bus.tx_data   = tx_data_q;
   assign bus.tx_start  = tx_start_q;
   assign bus.grant_id  = grant_q;
   assign bus.active    = active_q;
   assign bus.dbg_state = state;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter
// Drives uart_tx_arbiter with per-requester byte queues, emulates uart_tx
// (16 clocks per bit, 10-bit frame, tx_busy high from the tx_start cycle),
// and checks every cycle against a transaction-level round-robin model.
module tb_uart_tx_arbiter;
   localparam int NUM_REQ   = 4;
   localparam int BIT_CYC   = 16;
   localparam int FRAME_CYC = 10 * BIT_CYC;
`ifdef UART_ARB_PKT_LOCK_EN
   localparam bit LOCK_EN = 1'b1;
`else
   localparam bit LOCK_EN = 1'b0;
`endif

   // ---------------- clock / reset ----------------
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

   uart_tx_arbiter #(.NUM_REQ(NUM_REQ)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // ---------------- uart_tx stand-in (never reset) ----------------
   logic       uart_run   = 1'b0;
   int         uart_el    = 0;
   logic [9:0] uart_frame = 10'h3ff;
   logic       tx_line;

   always @(posedge clk) begin
      if (bus.tx_start) begin
         uart_run   <= 1'b1;
         uart_el    <= 0;
         uart_frame <= {1'b1, bus.tx_data, 1'b0};
      end else if (uart_run) begin
         if (uart_el == FRAME_CYC - 1) uart_run <= 1'b0;
         else uart_el <= uart_el + 1;
      end
   end

   assign bus.tx_busy = bus.tx_start | uart_run;
   assign tx_line     = uart_run ? uart_frame[uart_el / BIT_CYC] : 1'b1;

   // ---------------- bookkeeping ----------------
   logic [8:0] rq [NUM_REQ][$];   // {last, byte} waiting per requester
   int         valid_pct = 100;
   int         n_total   = 0;
   int         n_bad     = 0;
   int         n_start   = 0;
   logic [7:0] exp_q[$];          // bytes expected on the serial line
   int         acc_id_log[$];
   logic [7:0] acc_byte_log[$];
   logic [7:0] rx_byte = 8'h00;

   // Reference model: phase 0 = may accept, 1 = start pulse due, 2 = byte on line
   int         m_phase   = 0;
   int         m_ptr     = 0;
   bit         m_lock    = 1'b0;
   int         m_lock_id = 0;
   int         m_id      = 0;
   logic [7:0] m_byte    = 8'h00;

   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- driver ----------------
   task automatic push(int id, logic [7:0] b, bit last);
      rq[id].push_back({last, b});
   endtask

   task automatic drive_reqs();
      logic [8:0] h;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (rq[i].size() > 0 && $urandom_range(99) < valid_pct) begin
            h = rq[i][0];
            bus.req_valid[i]         = 1'b1;
            bus.req_data[8*i +: 8]   = h[7:0];
            bus.req_last[i]          = h[8];
         end else begin
            bus.req_valid[i]         = 1'b0;
            bus.req_data[8*i +: 8]   = 8'($urandom);
            bus.req_last[i]          = 1'($urandom_range(1));
         end
      end
   endtask

   initial begin
      forever begin
         @(posedge clk);
         #1;
         drive_reqs();
      end
   end

   // ---------------- model + scoreboard, sampled on the falling edge ----------------
   always @(negedge clk) begin
      logic [NUM_REQ-1:0] exp_ready;
      logic [8:0]         ent;
      bit                 found;
      int                 w;
      int                 c;
      int                 b;
      if (!rst_n) begin
         check("rst_req_ready", bus.req_ready, 0);
         check("rst_tx_start", bus.tx_start, 0);
         check("rst_tx_data", bus.tx_data, 8'h00);
         check("rst_grant_id", bus.grant_id, 0);
         check("rst_active", bus.active, 0);
         m_phase = 0;
         m_ptr   = 0;
         m_lock  = 1'b0;
      end else begin
         exp_ready = '0;
         found     = 1'b0;
         w         = 0;
         if (m_phase == 0 && !bus.tx_busy) begin
            for (int k = 0; k < NUM_REQ; k++) begin
               c = (m_ptr + k) % NUM_REQ;
               if (!found && bus.req_valid[c] && (!m_lock || c == m_lock_id)) begin
                  found = 1'b1;
                  w     = c;
               end
            end
         end
         if (found) exp_ready[w] = 1'b1;
         check("req_ready", bus.req_ready, exp_ready);
         check("tx_start", bus.tx_start, m_phase == 1);
         check("active", bus.active, (m_phase != 0) || m_lock);
         if (bus.tx_start) begin
            n_start++;
            check("overlap", uart_run, 0);
         end
         case (m_phase)
            0: begin
               if (found && rq[w].size() > 0) begin
                  ent    = rq[w].pop_front();
                  m_byte = ent[7:0];
                  m_id   = w;
                  exp_q.push_back(ent[7:0]);
                  acc_id_log.push_back(w);
                  acc_byte_log.push_back(ent[7:0]);
                  if (LOCK_EN && !ent[8]) begin
                     m_lock    = 1'b1;
                     m_lock_id = w;
                  end else begin
                     m_lock = 1'b0;
                     m_ptr  = (w + 1) % NUM_REQ;
                  end
                  m_phase = 1;
               end
            end
            1: begin
               check("tx_data", bus.tx_data, m_byte);
               check("grant_id", bus.grant_id, m_id);
               m_phase = 2;
            end
            default: begin
               check("tx_hold", bus.tx_data, m_byte);
               if (!bus.tx_busy) m_phase = 0;
            end
         endcase
      end
      // serial line: sample mid-bit, LSB first
      if (uart_run && (uart_el % BIT_CYC) == BIT_CYC / 2) begin
         b = uart_el / BIT_CYC;
         if (b == 0) begin
            check("start_bit", tx_line, 0);
         end else if (b <= 8) begin
            rx_byte[b-1] = tx_line;
         end else begin
            check("stop_bit", tx_line, 1);
            check("line_pending", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) check("line_byte", rx_byte, exp_q.pop_front());
         end
      end
   end

   // ---------------- sequencing helpers ----------------
   function automatic bit all_empty();
      for (int i = 0; i < NUM_REQ; i++) if (rq[i].size() != 0) return 1'b0;
      return 1'b1;
   endfunction

   task automatic wait_idle(string tag, int max_cyc);
      int n = 0;
      while (n < max_cyc && !(all_empty() && m_phase == 0 && !uart_run && !bus.tx_start)) begin
         @(posedge clk);
         n++;
      end
      check({"idle_", tag}, n < max_cyc, 1);
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic wait_start(string tag, int base, int max_cyc);
      int n = 0;
      while (n_start == base && n < max_cyc) begin
         @(posedge clk);
         n++;
      end
      #1;
      check({"start_", tag}, n_start != base, 1);
   endtask

   task automatic apply_reset(int cycles);
      rst_n = 1'b0;
      repeat (cycles) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   // Accept log vs expectation; element 0 sits in the low bits of ids/bytes.
   task automatic check_log(string tag, int n, logic [31:0] ids, logic [63:0] bytes);
      check({tag, "_count"}, acc_id_log.size(), n);
      for (int k = 0; k < n && k < acc_id_log.size(); k++) begin
         check({tag, "_id"}, acc_id_log[k], ids[4*k +: 4]);
         check({tag, "_byte"}, acc_byte_log[k], bytes[8*k +: 8]);
      end
      acc_id_log.delete();
      acc_byte_log.delete();
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int s0;
      int pushed;
      bus.req_valid = '0;
      bus.req_data  = '0;
      bus.req_last  = '0;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;

      // single byte from req0
      s0 = n_start;
      push(0, 8'hA5, 1'b1);
      wait_idle("single", 400);
      check("single_starts", n_start - s0, 1);
      check_log("single", 1, 32'h0, 64'hA5);

      // fairness from a fresh pointer
      apply_reset(2);
      push(0, 8'h10, 1'b1);
      push(0, 8'h10, 1'b1);
      push(1, 8'h20, 1'b1);
      push(2, 8'h30, 1'b1);
      push(3, 8'h40, 1'b1);
      wait_idle("fair", 1500);
      check_log("fair", 5, 32'h03210, 64'h10_40_30_20_10);

      // wrap: serve req2 so the pointer sits at 3, then req3 and req0 compete
      push(2, 8'h33, 1'b1);
      wait_idle("wrap_a", 400);
      push(3, 8'h44, 1'b1);
      push(0, 8'h55, 1'b1);
      wait_idle("wrap_b", 700);
      check_log("wrap", 3, 32'h032, 64'h55_44_33);

      // three-byte packet on req1 against a single byte on req2
      push(1, 8'h01, 1'b0);
      push(1, 8'h02, 1'b0);
      push(1, 8'h03, 1'b1);
      push(2, 8'hFF, 1'b1);
      wait_idle("pkt", 1500);
`ifdef UART_ARB_PKT_LOCK_EN
      check_log("pkt", 4, 32'h2111, 64'hFF_03_02_01);
`else
      check_log("pkt", 4, 32'h1121, 64'h03_02_FF_01);
`endif

      // reset in the middle of the data bits
      s0 = n_start;
      push(0, 8'h5A, 1'b1);
      push(0, 8'h6B, 1'b1);
      wait_start("rst_mid", s0, 50);
      repeat (40) @(posedge clk);
      #1;
      apply_reset(2);
      wait_idle("rst_mid", 800);
      check("rst_mid_starts", n_start - s0, 2);
      check_log("rst_mid", 2, 32'h00, 64'h6B_5A);

      // req2 offers a byte during WAIT and withdraws it
      s0 = n_start;
      push(0, 8'h71, 1'b1);
      wait_start("withdraw", s0, 50);
      repeat (20) @(posedge clk);
      #1;
      push(2, 8'h77, 1'b1);
      repeat (30) @(posedge clk);
      #1;
      rq[2].delete();
      wait_idle("withdraw", 400);
      check("withdraw_starts", n_start - s0, 1);
      check_log("withdraw", 1, 32'h0, 64'h71);

      // randomized packets with intermittent req_valid
      valid_pct = 70;
      pushed    = 0;
      for (int p = 0; p < 16; p++) begin
         int id;
         int len;
         id  = $urandom_range(NUM_REQ - 1);
         len = $urandom_range(3, 1);
         for (int j = 0; j < len; j++) begin
            push(id, 8'($urandom), j == len - 1);
            pushed++;
         end
      end
      wait_idle("rand", 20000);
      check("rand_count", acc_id_log.size(), pushed);
      check("rand_line_drained", exp_q.size(), 0);
      acc_id_log.delete();
      acc_byte_log.delete();

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule
